// File: rtl/hmmm_out_port.sv
// hmmm_out_port
//   Output stage between the Hmmm core's `write rX` path and the user GPIO pins.
//   The core pushes words into a small FIFO using valid/ready. A two-state FSM pops
//   each word onto the pin bus, zero-extended, and holds it there for at least
//   HOLD_CYCLES cycles. A slow external observer therefore sees every value in order.
//   out_strobe toggles once per loaded value, so repeated equal values stay
//   distinguishable.
//
//   Handshake: a word transfers on a rising edge where wr_valid && wr_ready.
//   wr_ready is registered and reflects the FIFO count at the start of the cycle.
//   wr_valid/wr_data may change freely while wr_ready is low.
//
// Ports
//   wb_clk_i    in   1       clock, all state on rising edge
//   resetb      in   1       synchronous active-low reset
//   wr_valid    in   1       core presents a value
//   wr_data     in   DATA_W  value to output
//   wr_ready    out  1       block accepts wr_data this cycle
//   io_out      out  PIN_W   pin data, zero-extended shown value
//   io_oeb      out  PIN_W   pin output enable, active low
//   out_strobe  out  1       toggles on every newly loaded value
//   busy        out  1       FIFO non-empty or a value is still in its hold window
module hmmm_out_port #(
    parameter int DATA_W      = 16,
    parameter int PIN_W       = 21,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              wb_clk_i,
    input  logic              resetb,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [PIN_W-1:0]  io_out,
    output logic [PIN_W-1:0]  io_oeb,
    output logic              out_strobe,
    output logic              busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [HOLD_W-1:0]  hold;
    logic               hold_done;
    logic               push;
    logic               pop;

    // wr_ready is low whenever the FIFO is full, so a push never overruns it.
    // A pop needs count != 0, so a push into an empty FIFO is never shown in the
    // same cycle. That gives the one-edge latency with no combinational bypass.
    assign push      = wr_valid && wr_ready;
    assign hold_done = (hold == '0);
    assign pop       = (count != '0) && ((state == IDLE) || hold_done);

    always_comb begin
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        state_next = state;
        if (pop) begin
            state_next = SHOW;
        end else if ((state == SHOW) && hold_done) begin
            state_next = IDLE;
        end
    end

    // Storage has no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetb) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold       <= '0;
            io_out     <= '0;
            io_oeb     <= '1;
            out_strobe <= 1'b0;
            wr_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            io_oeb   <= '0;
            state    <= state_next;
            count    <= count_next;
            wr_ready <= (count_next < DEPTH_C);
            busy     <= (count_next != '0) || (state_next == SHOW);

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop) begin
                io_out     <= PIN_W'(mem[rd_ptr]);
                rd_ptr     <= rd_ptr + PTR_W'(1);
                out_strobe <= ~out_strobe;
                hold       <= HOLD_LOAD;
            end else if ((state == SHOW) && !hold_done) begin
                hold <= hold - HOLD_W'(1);
            end
        end
    end

endmodule
